qinv_mult_arbiter: RTL and testbench
====================================

QINV_MULT_ARBITER -- requirements
Module: qinv_mult_arbiter

Interface
REQ-001 The block SHALL have a parameter NREQ, default 4, giving the number of requesters (power of two, 2..8).
REQ-002 The block SHALL have a parameter FIFO_DEPTH, default 2, giving the response FIFO entries (fixed at 2 in this revision).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operand valid.
REQ-006 req_ready  output  NREQ  per-requester grant, one-hot or zero.
REQ-007 req_data  input  32*NREQ  operands; requester i occupies bits [32i+31:32i].
REQ-008 rsp_valid  output  1  response available.
REQ-009 rsp_ready  input  1  consumer accepts response.
REQ-010 rsp_id  output  log2(NREQ)  index of the requester that issued the response.
REQ-011 rsp_data  output  16  operand[15:0]*QINV mod 2^16.
REQ-012 busy  output  1  high while any operation is in flight or the FIFO is non-empty.

Function
REQ-013 The block SHALL share one QINV multiplier (QINV = 0xF301, 1-cycle registered latency) among NREQ requesters.
REQ-014 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-015 req_ready SHALL be combinational from req_valid, the round-robin pointer and credit, and SHALL never depend on req_data.
REQ-016 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid high.
REQ-017 Credit SHALL equal FIFO_DEPTH - fifo_count - inflight + (rsp_valid & rsp_ready); a grant SHALL be issued only when credit > 0.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer p; after a grant to i, p becomes (i+1) mod NREQ; p SHALL be unchanged when no grant is issued.
REQ-019 On a grant, the granted operand SHALL drive the multiplier input, and inflight/tag registers SHALL capture 1 and i.
REQ-020 One cycle after the grant, the multiplier result and its tag SHALL be pushed into the FIFO.
REQ-021 Latency: for an operand accepted in cycle n with an empty FIFO, rsp_valid SHALL be high in cycle n+2.
REQ-022 rsp_valid SHALL equal FIFO not-empty; rsp_id and rsp_data SHALL show the head entry and SHALL stay stable while rsp_valid & !rsp_ready.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged and preserve order; responses SHALL be returned strictly in grant order.
REQ-024 Overflow SHALL be impossible by construction; the bench SHALL assert that a push never occurs while count == FIFO_DEPTH without a pop.
REQ-025 Sustained throughput SHALL be one operation per cycle while rsp_ready is held high.
REQ-026 busy SHALL equal inflight | (fifo_count != 0).

Reset
REQ-027 While rst_n is low, the block SHALL hold: req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, p = 0, fifo_count = 0, inflight = 0.
REQ-028 Reset assertion mid-operation SHALL discard in-flight and queued results without emitting them.
REQ-029 The multiplier synchronous reset SHALL be driven by ~rst_n.
REQ-030 The first grant after reset SHALL favour requester 0.

Structure
REQ-031 A shared package SHALL hold QINV, KYBER_Q (3329), and the response-entry typedef {id, data[15:0]}.
REQ-032 The block SHALL instantiate exactly one sub-module, mult_constants_qinv, as the shared multiplier; the arbiter, credit logic and FIFO SHALL stay inline.

Verification
REQ-033 With only req0 valid and req_data[31:0] = 0x0000_0001 accepted in cycle n, the bench SHALL see rsp_valid in cycle n+2 with rsp_id = 0 and rsp_data = 0xF301.
REQ-034 With all four requesters valid continuously and rsp_ready = 1, the bench SHALL see grants ordered 0,1,2,3,0,... one per cycle; operands 2, 3, 0x0001_0000, 0xFFFF give responses 0xE602, 0xD903, 0x0000, 0x0CFF with ids 0..3.
REQ-035 With rsp_ready = 0 and all requesters valid, exactly 2 operations SHALL be accepted and req_ready SHALL then stay 0; raising rsp_ready SHALL pop one entry per cycle and resume grants the same cycle.
REQ-036 With FIFO count = 1 and a simultaneous push and pop, the count SHALL remain 1 and the next rsp_data SHALL equal the newly pushed value.
REQ-037 rst_n pulsed low asynchronously between edges with 1 in flight and 1 queued SHALL immediately clear all outputs to 0, emit no stale response afterwards, and make the next grant go to requester 0.

Source files
------------

// File: rtl/qinv_mult_arbiter_pkg.sv
// Shared constants and the response-FIFO entry type for qinv_mult_arbiter.
package qinv_mult_arbiter_pkg;

    // Multiplicative constant applied to every operand (result kept mod 2^16).
    localparam logic [15:0] QINV = 16'hF301;

    // Kyber modulus, kept alongside QINV for the datapaths that share it.
    localparam int unsigned KYBER_Q = 3329;

    // Widest requester index supported (NREQ up to 8).
    localparam int unsigned ID_W_MAX = 3;

    // One queued response: which requester issued it and the product.
    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [15:0]         data;
    } rsp_entry_t;

endpackage

// File: rtl/qinv_mult_arbiter_mult.sv
// Shared constant multiplier: p = a * QINV mod 2^16, one registered stage.
module mult_constants_qinv
(
    input  logic        clk,
    input  logic        srst,
    input  logic [15:0] a,
    output logic [15:0] p
);
    import qinv_mult_arbiter_pkg::*;

    logic [15:0] prod;

    // 16-bit context keeps only the low half of the product.
    always_comb begin
        prod = a * QINV;
    end

    // Registered product, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            p <= '0;
        end else begin
            p <= prod;
        end
    end

endmodule

// File: rtl/qinv_mult_arbiter.sv
// Round-robin arbiter sharing one QINV multiplier among NREQ requesters,
// with credit-based flow control into a small in-order response FIFO.
module qinv_mult_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [32*NREQ-1:0]      req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [15:0]             rsp_data,
    output logic                    busy
);
    import qinv_mult_arbiter_pkg::*;

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [IDW-1:0] rr_ptr;
    logic           inflight;
    logic [IDW-1:0] tag;
    logic [CW-1:0]  fifo_count;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    rsp_entry_t     fifo_mem [FIFO_DEPTH];
    rsp_entry_t     head;
    rsp_entry_t     push_entry;

    logic           credit_ok;
    logic           grant;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           push;
    logic           pop;
    logic [15:0]    mult_a;
    logic [15:0]    mult_p;
    logic           mult_srst;
    logic           unused_id_bits;

    // Credit: a slot is free if entries held plus the one in flight are
    // below depth, counting the entry being popped this cycle as freed.
    always_comb begin
        pop       = rsp_valid & rsp_ready;
        push      = inflight;
        credit_ok = rst_n &&
                    ((DEPTH_C + (CW+1)'(pop)) >
                     ((CW+1)'(fifo_count) + (CW+1)'(inflight)));
    end

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (credit_ok) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = rr_ptr + IDW'(k);
                if (!grant && req_valid[cand]) begin
                    grant     = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Granted operand's low half feeds the shared multiplier.
    always_comb begin
        mult_a    = req_data[32*int'(grant_idx) +: 16];
        mult_srst = ~rst_n;
    end

    mult_constants_qinv u_mult (
        .clk  (clk),
        .srst (mult_srst),
        .a    (mult_a),
        .p    (mult_p)
    );

    // Pointer advances past the winner; inflight/tag track the operation
    // whose product appears at the multiplier output next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            inflight <= 1'b0;
            tag      <= '0;
        end else begin
            inflight <= grant;
            if (grant) begin
                tag    <= grant_idx;
                rr_ptr <= grant_idx + IDW'(1);
            end
        end
    end

    // Entry captured from the multiplier output and its tag.
    always_comb begin
        push_entry      = '0;
        push_entry.id   = ID_W_MAX'(tag);
        push_entry.data = mult_p;
    end

    // Response FIFO: push on the cycle after a grant, pop on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                fifo_mem[e] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // Head entry and status outputs.
    always_comb begin
        head           = fifo_mem[rd_ptr];
        rsp_valid      = (fifo_count != '0);
        rsp_id         = head.id[IDW-1:0];
        rsp_data       = head.data;
        busy           = inflight | (fifo_count != '0);
        unused_id_bits = ^head.id;
    end

endmodule

// File: tb/tb_qinv_mult_arbiter.sv
// Scoreboard bench for qinv_mult_arbiter: stimulus queues expected grants
// and responses, a negedge monitor pops and compares them.
module tb_qinv_mult_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_data = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [15:0]  rsp_data;
    logic         busy;

    qinv_mult_arbiter #(.NREQ(4), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          gcyc;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_q[$];
    logic [15:0] exp_tab [4];
    int          cyc = 0;
    int          grant_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          prev_valid = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void flag(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: grant order, protocol rules, latency and response scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 1);
            check("ready_without_valid", 32'(req_ready & ~req_valid), 0);
            check("no_overflow_push",
                  32'(dut.inflight && (dut.fifo_count == 2) && !(rsp_valid && rsp_ready)), 0);
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    grant_cnt++;
                    if (grant_q.size() == 0) flag("unexpected_grant");
                    else check("grant_order", i, grant_q.pop_front());
                    exp_q.push_back('{i, exp_tab[i], cyc});
                end
            end
            if (rsp_valid && !prev_valid && exp_q.size() > 0)
                check("rsp_latency", cyc - exp_q[0].gcyc, 2);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_response");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), e.id);
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic set_op(int i, logic [31:0] d, logic [15:0] e);
        req_data[32*i +: 32] = d;
        exp_tab[i] = e;
    endtask

    task automatic run_grants(int n, int budget);
        int target;
        target = grant_cnt + n;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (grant_cnt >= target) break;
        end
        if (grant_cnt < target) flag("grant_timeout");
    endtask

    task automatic wait_idle(int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0) break;
        end
        if (busy || exp_q.size() != 0) flag("drain_timeout");
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fifo_count", 32'(dut.fifo_count), 0);
        check("rst_inflight", 32'(dut.inflight), 0);
        check("rst_rr_ptr", 32'(dut.rr_ptr), 0);
        exp_q.delete();
        grant_q.delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int c0;

        // Reset with all requesters valid: no grant may leak out.
        req_valid = 4'hF;
        do_reset();

        // Single operation from requester 0, operand 1.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        set_op(0, 32'h0000_0001, 16'hF301);
        grant_q.push_back(0);
        req_valid = 4'b0001;
        run_grants(1, 10);
        req_valid = '0;
        wait_idle(20);

        // Full-rate round robin from a fresh reset.
        do_reset();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        set_op(0, 32'h0000_0002, 16'hE602);
        set_op(1, 32'h0000_0003, 16'hD903);
        set_op(2, 32'h0001_0000, 16'h0000);
        set_op(3, 32'h0000_FFFF, 16'h0CFF);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) grant_q.push_back(i);
        c0 = cyc;
        req_valid = 4'hF;
        run_grants(8, 40);
        check("throughput_cycles", cyc - c0, 8);
        req_valid = '0;
        wait_idle(20);

        // Back-pressure: credit stops grants after two, resumes on pop.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_op(0, 32'h0000_0004, 16'hCC04);
        set_op(1, 32'h0000_0005, 16'hBF05);
        set_op(2, 32'h0000_0100, 16'h0100);
        set_op(3, 32'h0000_8000, 16'h8000);
        grant_q.push_back(0);
        grant_q.push_back(1);
        c0 = grant_cnt;
        req_valid = 4'hF;
        run_grants(2, 10);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("stall_req_ready", 32'(req_ready), 0);
        end
        check("stall_grant_count", grant_cnt - c0, 2);
        check("stall_fifo_full", 32'(dut.fifo_count), 2);
        rsp_ready = 1'b1;
        #1;
        check("resume_same_cycle", 32'(req_ready), 32'h4);
        grant_q.push_back(2);
        grant_q.push_back(3);
        grant_q.push_back(0);
        grant_q.push_back(1);
        run_grants(4, 20);
        req_valid = '0;
        wait_idle(20);

        // Simultaneous push and pop with one entry queued.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_op(0, 32'h0000_0007, 16'hA507);
        grant_q.push_back(0);
        req_valid = 4'b0001;
        run_grants(1, 10);
        req_valid = '0;
        repeat (2) begin @(posedge clk); #1; end
        check("pp_count_before", 32'(dut.fifo_count), 1);
        set_op(1, 32'h0000_0009, 16'h8B09);
        grant_q.push_back(1);
        req_valid = 4'b0010;
        run_grants(1, 10);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("pp_count_after", 32'(dut.fifo_count), 1);
        check("pp_rsp_valid", 32'(rsp_valid), 1);
        check("pp_rsp_data", 32'(rsp_data), 32'h8B09);
        rsp_ready = 1'b1;
        wait_idle(20);

        // Asynchronous reset with one in flight and one queued.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        grant_q.push_back(2);
        grant_q.push_back(3);
        req_valid = 4'hF;
        run_grants(2, 10);
        req_valid = '0;
        check("pre_rst_busy", 32'(busy), 1);
        check("pre_rst_rsp_valid", 32'(rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 0);
        check("async_rsp_data", 32'(rsp_data), 0);
        check("async_rsp_id", 32'(rsp_id), 0);
        check("async_busy", 32'(busy), 0);
        check("async_req_ready", 32'(req_ready), 0);
        exp_q.delete();
        grant_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        check("post_rst_no_rsp", 32'(rsp_valid), 0);
        set_op(0, 32'h0000_0001, 16'hF301);
        grant_q.push_back(0);
        req_valid = 4'hF;
        run_grants(1, 10);
        req_valid = '0;
        wait_idle(20);

        check("leftover_responses", exp_q.size(), 0);
        check("leftover_grants", grant_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
